// File: rtl/data_mem_pkg.sv
// Shared encodings for the byte-addressable data memory: access sizes,
// controller states and the store lane-enable helper.
package data_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Lane enables for an aligned store of the given size at byte lane 'lane'.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_B:  be = 4'b0001 << lane;
            SIZE_H:  be = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_load_extract.sv
// Picks the addressed byte or half out of a memory word and widens it to
// 32 bits with either sign or zero fill.
module mem_load_extract
    import data_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    output logic [31:0] result_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word_i[{lane_i, 3'b000} +: 8];
        sel_half = lane_i[1] ? word_i[31:16] : word_i[15:0];
        result_o = word_i;
        case (size_i)
            SIZE_B:  result_o = {{24{sign_ext_i & sel_byte[7]}}, sel_byte};
            SIZE_H:  result_o = {{16{sign_ext_i & sel_half[15]}}, sel_half};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_byte.sv
// DEPTH x 32 data memory with byte/half/word access, one-cycle registered
// loads, rejected-access fault pulse and an optional zero sweep after reset.
module data_mem_byte
    import data_mem_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        fault,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [31:0]   mem [DEPTH];

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic [31:0]   rdata_q;
    logic          rvalid_q;
    logic          fault_q;

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          req;
    logic          bad;
    logic          store_ok;
    logic          load_ok;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   load_res;

    always_comb begin
        idx  = addr[AW+1:2];
        lane = addr[1:0];
        req  = (mem_read | mem_write) && (state_q == ST_IDLE);
        bad  = (size == SIZE_X)
            || ((size == SIZE_H) && addr[0])
            || ((size == SIZE_W) && (lane != 2'b00))
            || (addr[31:AW+2] != '0)
            || (mem_read && mem_write);
        store_ok = req && mem_write && !bad;
        load_ok  = req && mem_read && !bad;
    end

    // The sweep owns the write port while busy; stores replicate data across lanes.
    always_comb begin
        wr_idx  = idx;
        wr_be   = store_ok ? lane_be(size, lane) : 4'b0000;
        wr_data = (size == SIZE_B) ? {4{wdata[7:0]}} :
                  (size == SIZE_H) ? {2{wdata[15:0]}} : wdata;
        if (state_q == ST_CLEAR) begin
            wr_idx  = cnt_q;
            wr_be   = 4'b1111;
            wr_data = 32'h0;
        end
        wr_be = wr_be & {4{~reset}};
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    mem_load_extract u_extract (
        .word_i     (mem[idx]),
        .lane_i     (lane),
        .size_i     (size),
        .sign_ext_i (sign_ext),
        .result_o   (load_res)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= INIT_CLEAR ? ST_CLEAR : ST_IDLE;
            cnt_q    <= '0;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            rvalid_q <= load_ok;
            fault_q  <= req && bad;
            if (load_ok) rdata_q <= load_res;
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign fault  = fault_q;
    assign busy   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_data_mem_byte.sv
// Bench for data_mem_byte (DEPTH=64): byte-level reference memory, expected
// load results queued at issue and compared when rvalid appears.
module tb_data_mem_byte;
    import data_mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] rdata;
    logic        rvalid;
    logic        fault;
    logic        busy;

    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [64];
    logic [31:0] last_rdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    data_mem_byte #(.DEPTH(64), .INIT_CLEAR(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .size      (size),
        .sign_ext  (sign_ext),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .fault     (fault),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == SIZE_B) ? 1 : (sz == SIZE_H) ? 2 : 4;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] ba;
        for (int i = 0; i < nbytes(sz); i++) begin
            ba = a + 32'(i);
            ref_mem[ba[7:2]][8*ba[1:0] +: 8] = d[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        logic [31:0] ba;
        logic [31:0] v;
        int          nb;
        nb = nbytes(sz);
        v  = 32'h0;
        for (int i = 0; i < nb; i++) begin
            ba = a + 32'(i);
            v[8*i +: 8] = ref_mem[ba[7:2]][8*ba[1:0] +: 8];
        end
        if (sx && v[8*nb-1]) begin
            for (int j = 8*nb; j < 32; j++) v[j] = 1'b1;
        end
        return v;
    endfunction

    // One request cycle: drive, clock, then check fault/rvalid/rdata.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input logic sx,
                          input logic exp_fault, input logic exp_rv, input string tag);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        size      = sz;
        sign_ext  = sx;
        @(posedge clock);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check_eq({tag, "_fault"}, {31'h0, fault}, {31'h0, exp_fault});
        check_eq({tag, "_rvalid"}, {31'h0, rvalid}, {31'h0, exp_rv});
        if (rvalid && exp_q.size() > 0) begin
            last_rdata = exp_q.pop_front();
            check_eq({tag, "_rdata"}, rdata, last_rdata);
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input string tag);
        model_store(a, d, sz);
        access(1'b0, 1'b1, a, d, sz, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sx, input string tag);
        exp_q.push_back(model_load(a, sz, sx));
        access(1'b1, 1'b0, a, 32'h0, sz, sx, 1'b0, 1'b1, tag);
    endtask

    task automatic do_bad(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz, input string tag);
        access(rd, wr, a, 32'hCAFEF00D, sz, 1'b1, 1'b1, 1'b0, tag);
    endtask

    task automatic count_busy(input string tag, input logic drive_req);
        int   n;
        logic stray;
        n     = 0;
        stray = 1'b0;
        while (busy && n < 200) begin
            mem_read  = drive_req & n[0];
            mem_write = drive_req & ~n[0];
            addr      = 32'h44;
            wdata     = 32'hFFFFFFFF;
            size      = SIZE_W;
            @(posedge clock);
            #1;
            stray = stray | rvalid | fault;
            n++;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check_eq({tag, "_cycles"}, 32'(n), 32'd64);
        check_eq({tag, "_stray"}, {31'h0, stray}, 32'h0);
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    endtask

    initial begin
        reset = 1'b1; addr = 32'h0; wdata = 32'h0;
        mem_write = 1'b0; mem_read = 1'b0; size = SIZE_W; sign_ext = 1'b0;
        last_rdata = 32'h0;
        #1;
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check_eq("rst_fault", {31'h0, fault}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h1);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        count_busy("sweep", 1'b0);

        do_load(32'h00FC, SIZE_W, 1'b0, "ld_fc");

        do_store(32'h10, 32'h11223344, SIZE_W, "st_10");
        do_store(32'h12, 32'h000000AA, SIZE_B, "st_12b");
        do_load(32'h10, SIZE_W, 1'b0, "ld_10");
        access(1'b0, 1'b0, 32'h0, 32'h0, SIZE_W, 1'b0, 1'b0, 1'b0, "idle");
        check_eq("rdata_hold", rdata, 32'h11AA3344);

        do_store(32'h20, 32'h8000FF7F, SIZE_W, "st_20");
        do_load(32'h20, SIZE_B, 1'b1, "ldb_20s");
        do_load(32'h21, SIZE_B, 1'b1, "ldb_21s");
        do_load(32'h22, SIZE_H, 1'b0, "ldh_22z");
        do_load(32'h22, SIZE_H, 1'b1, "ldh_22s");
        do_load(32'h21, SIZE_B, 1'b0, "ldb_21z");

        do_bad(1'b0, 1'b1, 32'h31, SIZE_H, "bad_half");
        do_bad(1'b1, 1'b0, 32'h02, SIZE_W, "bad_word");
        do_bad(1'b0, 1'b1, 32'h100, SIZE_W, "bad_range");
        do_bad(1'b1, 1'b1, 32'h10, SIZE_W, "bad_rw");
        do_bad(1'b0, 1'b1, 32'h14, SIZE_X, "bad_size");
        do_load(32'h30, SIZE_W, 1'b0, "ld_30");
        do_load(32'h10, SIZE_W, 1'b0, "ld_10b");
        do_load(32'h14, SIZE_W, 1'b0, "ld_14");

        do_store(32'h40, 32'hDEADBEEF, SIZE_W, "st_40");
        do_load(32'h40, SIZE_W, 1'b0, "ld_40");

        for (int k = 0; k < 200; k++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 255));
            if (sz == SIZE_H) a[0] = 1'b0;
            if (sz == SIZE_W) a[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1)
                do_store(a, $urandom, sz, "rnd_st");
            else
                do_load(a, sz, 1'($urandom_range(0, 1)), "rnd_ld");
        end

        // A load whose result is showing when reset hits is wiped and never reappears.
        do_store(32'h10, 32'h11223344, SIZE_W, "st_10c");
        mem_read = 1'b1; addr = 32'h10; size = SIZE_W; sign_ext = 1'b0;
        @(posedge clock);
        #1 mem_read = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("flight_rdata", rdata, 32'h0);
        check_eq("flight_rvalid", {31'h0, rvalid}, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        check_eq("flight_drop", {31'h0, rvalid}, 32'h0);

        repeat (29) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        count_busy("resweep", 1'b1);
        do_load(32'h44, SIZE_W, 1'b0, "ld_44");
        do_load(32'h10, SIZE_W, 1'b0, "ld_10z");
        do_load(32'h7C, SIZE_H, 1'b1, "ld_7c");

        check_eq("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
